// File: rtl/framebuffer_write_arbiter.sv
// framebuffer_write_arbiter
//   Shares a single framebuffer write port between a CPU pixel-write
//   interface and a rectangle-outline draw engine. Each cycle at most one
//   pixel is written. When both sides want the port, a round-robin
//   last_grant flag decides.
//
// Ports
//   CLK, RESET            clock, asynchronous active-high reset
//   CPU_REQ/ADDR/DATA     CPU write request, held until CPU_ACK
//   CPU_ACK               one-cycle pulse, coincides with the CPU write on WRITE_EN
//   DRAW_START            pulse that starts an outline draw (ignored while busy)
//   DRAW_X0/X1, Y0/Y1     rectangle corners (any order, clamped to the screen)
//   DRAW_COLOR            outline colour
//   DRAW_BUSY, DRAW_DONE  draw in progress / one-cycle completion pulse
//   WRITE_EN/ADDR/DATA    registered framebuffer write port
module framebuffer_write_arbiter #(
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CPU_REQ,
  input  logic [18:0] CPU_ADDR,
  input  logic [23:0] CPU_DATA,
  output logic        CPU_ACK,
  input  logic        DRAW_START,
  input  logic [9:0]  DRAW_X0,
  input  logic [9:0]  DRAW_X1,
  input  logic [8:0]  DRAW_Y0,
  input  logic [8:0]  DRAW_Y1,
  input  logic [23:0] DRAW_COLOR,
  output logic        DRAW_BUSY,
  output logic        DRAW_DONE,
  output logic        WRITE_EN,
  output logic [18:0] WRITE_ADDR,
  output logic [23:0] WRITE_DATA
);

  localparam logic [9:0] X_LIM = 10'(H_RES - 1);
  localparam logic [8:0] Y_LIM = 9'(V_RES - 1);

  typedef enum logic [2:0] {IDLE, TOP, BOTTOM, LEFT, RIGHT, FINISH} state_t;

  state_t      state_reg, state_next;
  logic [9:0]  xmin_reg, xmax_reg, x_cnt_reg, x_cnt_next;
  logic [8:0]  ymin_reg, ymax_reg, y_cnt_reg, y_cnt_next;
  logic [23:0] color_reg;
  logic        last_grant_draw_reg;   // 1 = draw engine won the most recent grant

  logic [9:0]  x_lo, x_hi;
  logic [8:0]  y_lo, y_hi;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [18:0] pix_addr;
  logic [8:0]  y_span;
  logic        start_accept, draw_pending, cpu_eligible, grant_cpu, grant_draw;

  // Normalise the corners, then clamp both ends to the visible area.
  always_comb begin
    x_lo = (DRAW_X0 < DRAW_X1) ? DRAW_X0 : DRAW_X1;
    x_hi = (DRAW_X0 < DRAW_X1) ? DRAW_X1 : DRAW_X0;
    y_lo = (DRAW_Y0 < DRAW_Y1) ? DRAW_Y0 : DRAW_Y1;
    y_hi = (DRAW_Y0 < DRAW_Y1) ? DRAW_Y1 : DRAW_Y0;
    if (x_lo > X_LIM) x_lo = X_LIM;
    if (x_hi > X_LIM) x_hi = X_LIM;
    if (y_lo > Y_LIM) y_lo = Y_LIM;
    if (y_hi > Y_LIM) y_hi = Y_LIM;
  end

  // DRAW_BUSY is low exactly when the FSM sits in IDLE.
  assign start_accept = DRAW_START && (state_reg == IDLE);
  assign draw_pending = (state_reg == TOP) || (state_reg == BOTTOM) ||
                        (state_reg == LEFT) || (state_reg == RIGHT);
  // The cycle carrying CPU_ACK is never eligible, which spaces CPU writes.
  assign cpu_eligible = CPU_REQ && !CPU_ACK;
  assign grant_cpu    = cpu_eligible && (!draw_pending || last_grant_draw_reg);
  assign grant_draw   = draw_pending && !grant_cpu;
  assign y_span       = ymax_reg - ymin_reg;

  // Current outline pixel for each edge of the rectangle.
  always_comb begin
    pix_x = x_cnt_reg;
    pix_y = ymin_reg;
    case (state_reg)
      BOTTOM: pix_y = ymax_reg;
      LEFT: begin
        pix_x = xmin_reg;
        pix_y = y_cnt_reg;
      end
      RIGHT: begin
        pix_x = xmax_reg;
        pix_y = y_cnt_reg;
      end
      default: ;
    endcase
  end

  // Modulo-2^19 arithmetic gives the 19-bit truncation directly.
  assign pix_addr = 19'(pix_y) * 19'(H_RES) + 19'(pix_x);

  // Counters only move on a granted draw write, so a lost arbitration
  // simply retries the same pixel next cycle.
  always_comb begin
    state_next = state_reg;
    x_cnt_next = x_cnt_reg;
    y_cnt_next = y_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start_accept) begin
          state_next = TOP;
          x_cnt_next = x_lo;
        end
      end
      TOP: begin
        if (grant_draw) begin
          if (x_cnt_reg == xmax_reg) begin
            if (ymax_reg != ymin_reg) begin
              state_next = BOTTOM;
              x_cnt_next = xmin_reg;
            end else begin
              state_next = FINISH;
            end
          end else begin
            x_cnt_next = x_cnt_reg + 10'd1;
          end
        end
      end
      BOTTOM: begin
        if (grant_draw) begin
          if (x_cnt_reg == xmax_reg) begin
            if (y_span >= 9'd2) begin
              state_next = LEFT;
              y_cnt_next = ymin_reg + 9'd1;
            end else begin
              state_next = FINISH;
            end
          end else begin
            x_cnt_next = x_cnt_reg + 10'd1;
          end
        end
      end
      LEFT: begin
        if (grant_draw) begin
          if (y_cnt_reg == ymax_reg - 9'd1) begin
            if (xmax_reg != xmin_reg) begin
              state_next = RIGHT;
              y_cnt_next = ymin_reg + 9'd1;
            end else begin
              state_next = FINISH;
            end
          end else begin
            y_cnt_next = y_cnt_reg + 9'd1;
          end
        end
      end
      RIGHT: begin
        if (grant_draw) begin
          if (y_cnt_reg == ymax_reg - 9'd1) state_next = FINISH;
          else                               y_cnt_next = y_cnt_reg + 9'd1;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg           <= IDLE;
      x_cnt_reg           <= '0;
      y_cnt_reg           <= '0;
      xmin_reg            <= '0;
      xmax_reg            <= '0;
      ymin_reg            <= '0;
      ymax_reg            <= '0;
      color_reg           <= '0;
      last_grant_draw_reg <= 1'b1;   // CPU wins the first tie
      WRITE_EN            <= 1'b0;
      WRITE_ADDR          <= '0;
      WRITE_DATA          <= '0;
      CPU_ACK             <= 1'b0;
      DRAW_BUSY           <= 1'b0;
      DRAW_DONE           <= 1'b0;
    end else begin
      state_reg <= state_next;
      x_cnt_reg <= x_cnt_next;
      y_cnt_reg <= y_cnt_next;
      if (start_accept) begin
        xmin_reg  <= x_lo;
        xmax_reg  <= x_hi;
        ymin_reg  <= y_lo;
        ymax_reg  <= y_hi;
        color_reg <= DRAW_COLOR;
      end
      if (grant_cpu)       last_grant_draw_reg <= 1'b0;
      else if (grant_draw) last_grant_draw_reg <= 1'b1;

      WRITE_EN <= grant_cpu || grant_draw;
      CPU_ACK  <= grant_cpu;
      if (grant_cpu) begin
        WRITE_ADDR <= CPU_ADDR;
        WRITE_DATA <= CPU_DATA;
      end else if (grant_draw) begin
        WRITE_ADDR <= pix_addr;
        WRITE_DATA <= color_reg;
      end else begin
        WRITE_ADDR <= '0;
        WRITE_DATA <= '0;
      end
      // Busy mirrors "not IDLE"; the done pulse lands as the FSM returns
      // to IDLE, so it follows the last outline write with busy already low.
      DRAW_BUSY <= (state_next != IDLE);
      DRAW_DONE <= (state_reg == FINISH);
    end
  end

endmodule

// File: tb/tb_framebuffer_write_arbiter.sv
`timescale 1ns/1ps
module tb_framebuffer_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [18:0] cpu_addr;
  logic [23:0] cpu_data;
  logic        cpu_ack;
  logic        draw_start;
  logic [9:0]  draw_x0, draw_x1;
  logic [8:0]  draw_y0, draw_y1;
  logic [23:0] draw_color;
  logic        draw_busy, draw_done;
  logic        wr_en;
  logic [18:0] wr_addr;
  logic [23:0] wr_data;

  always #5 clk = ~clk;

  framebuffer_write_arbiter #(.H_RES(640), .V_RES(480)) dut (
    .CLK(clk), .RESET(rst),
    .CPU_REQ(cpu_req), .CPU_ADDR(cpu_addr), .CPU_DATA(cpu_data), .CPU_ACK(cpu_ack),
    .DRAW_START(draw_start), .DRAW_X0(draw_x0), .DRAW_X1(draw_x1),
    .DRAW_Y0(draw_y0), .DRAW_Y1(draw_y1), .DRAW_COLOR(draw_color),
    .DRAW_BUSY(draw_busy), .DRAW_DONE(draw_done),
    .WRITE_EN(wr_en), .WRITE_ADDR(wr_addr), .WRITE_DATA(wr_data)
  );

  typedef struct {
    int          cyc;
    logic [18:0] addr;
    logic [23:0] data;
    logic        ack;
  } wr_t;

  wr_t exp_q[$];
  int  done_q[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_bad = 0;
  wr_t e;
  int  s;
  int  acks;

  // Hand-computed outline of (10,20)-(12,22) on a 640-wide screen.
  int rect_a[8] = '{12810, 12811, 12812, 14090, 14091, 14092, 13450, 13452};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d",
               name, act, act, expv, expv, cyc);
    end
  endtask

  task automatic push_wr(input int c, input int addr, input logic [23:0] data, input logic ack);
    wr_t w;
    w.cyc = c; w.addr = 19'(addr); w.data = data; w.ack = ack;
    exp_q.push_back(w);
  endtask

  // Pulse DRAW_START for one cycle; returns the cycle number it was driven in.
  task automatic start_draw(input int x0, input int y0, input int x1, input int y1,
                            input logic [23:0] col, output int sc);
    @(negedge clk);
    draw_x0 = 10'(x0); draw_y0 = 9'(y0);
    draw_x1 = 10'(x1); draw_y1 = 9'(y1);
    draw_color = col;
    draw_start = 1'b1;
    sc = cyc;
    @(negedge clk);
    draw_start = 1'b0;
  endtask

  // Present a CPU request and hold it until acknowledged (bounded).
  task automatic cpu_write(input int addr, input logic [23:0] data);
    int k;
    cpu_req = 1'b1; cpu_addr = 19'(addr); cpu_data = data;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!cpu_ack && k < 20);
    n_cmp++;
    if (!cpu_ack) begin
      n_bad++;
      $display("FAIL cpu_ack_timeout: got no CPU_ACK in %0d cycles, required one", k);
    end
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (exp_q.size() != 0 || done_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: %0d writes and %0d done pulses pending, required 0",
               exp_q.size(), done_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or done.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        $display("write cyc=%0d addr=%0d data=%06h ack=%0b", cyc, wr_addr, wr_data, cpu_ack);
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_write: got addr %0d at cycle %0d, required no write", wr_addr, cyc);
        end else begin
          e = exp_q.pop_front();
          check("write_cycle", cyc, e.cyc);
          check("write_addr", 32'(wr_addr), 32'(e.addr));
          check("write_data", 32'(wr_data), 32'(e.data));
          check("cpu_ack", 32'(cpu_ack), 32'(e.ack));
        end
      end else if (cpu_ack) begin
        n_cmp++; n_bad++;
        $display("FAIL ack_without_write: got CPU_ACK=1 with WRITE_EN=0 at cycle %0d, required 0", cyc);
      end
      if (draw_done) begin
        $display("done  cyc=%0d busy=%0b", cyc, draw_busy);
        if (done_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_done: got DRAW_DONE at cycle %0d, required none", cyc);
        end else begin
          check("done_cycle", cyc, done_q.pop_front());
          check("done_busy", 32'(draw_busy), 0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_addr = '0; cpu_data = '0;
    draw_start = 1'b0; draw_x0 = '0; draw_x1 = '0; draw_y0 = '0; draw_y1 = '0;
    draw_color = '0;
    #2;
    check("rst_write_en", 32'(wr_en), 0);
    check("rst_write_addr", 32'(wr_addr), 0);
    check("rst_write_data", 32'(wr_data), 0);
    check("rst_cpu_ack", 32'(cpu_ack), 0);
    check("rst_draw_busy", 32'(draw_busy), 0);
    check("rst_draw_done", 32'(draw_done), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single CPU write: visible one cycle after the request.
    s = cyc;
    push_wr(s + 1, 100, 24'h123456, 1'b1);
    cpu_write(100, 24'h123456);
    cpu_req = 1'b0;
    drain(10);

    // Back-to-back CPU requests: the ack cycle is not eligible.
    s = cyc;
    push_wr(s + 1, 200, 24'hABCDEF, 1'b1);
    push_wr(s + 3, 201, 24'h010203, 1'b1);
    cpu_write(200, 24'hABCDEF);
    cpu_write(201, 24'h010203);
    cpu_req = 1'b0;
    drain(10);

    // Basic outline, plus a start pulse while busy that must be ignored.
    start_draw(10, 20, 12, 22, 24'h00A0B0, s);
    for (int i = 0; i < 8; i++) push_wr(s + 2 + i, rect_a[i], 24'h00A0B0, 1'b0);
    done_q.push_back(s + 10);
    check("busy_after_start", 32'(draw_busy), 1);
    @(negedge clk);
    draw_x0 = 10'd0; draw_y0 = 9'd0; draw_x1 = 10'd3; draw_y1 = 9'd3;
    draw_start = 1'b1;
    @(negedge clk);
    draw_start = 1'b0;
    drain(40);
    check("busy_after_done", 32'(draw_busy), 0);

    // Swapped corners give the same outline.
    start_draw(12, 22, 10, 20, 24'h112233, s);
    for (int i = 0; i < 8; i++) push_wr(s + 2 + i, rect_a[i], 24'h112233, 1'b0);
    done_q.push_back(s + 10);
    drain(40);

    // Single-pixel rectangle.
    start_draw(5, 5, 5, 5, 24'h445566, s);
    push_wr(s + 2, 3205, 24'h445566, 1'b0);
    done_q.push_back(s + 3);
    drain(40);

    // X1 beyond the right edge is clamped to 639.
    start_draw(630, 0, 700, 0, 24'h778899, s);
    for (int i = 0; i < 10; i++) push_wr(s + 2 + i, 630 + i, 24'h778899, 1'b0);
    done_q.push_back(s + 12);
    drain(40);

    // Contention: CPU and draw alternate, CPU wins the first tie.
    @(negedge clk);
    draw_x0 = 10'd10; draw_y0 = 9'd20; draw_x1 = 10'd12; draw_y1 = 9'd22;
    draw_color = 24'h00FF00;
    cpu_addr = 19'd7; cpu_data = 24'hFF0000;
    cpu_req = 1'b1;
    draw_start = 1'b1;
    s = cyc;
    for (int k = 0; k < 17; k++) begin
      if (k % 2 == 0) push_wr(s + 1 + k, 7, 24'hFF0000, 1'b1);
      else            push_wr(s + 1 + k, rect_a[(k - 1) / 2], 24'h00FF00, 1'b0);
    end
    done_q.push_back(s + 17);
    acks = 0;
    for (int k = 0; k < 40 && acks < 9; k++) begin
      @(negedge clk);
      draw_start = 1'b0;
      if (cpu_ack) acks++;
    end
    cpu_req = 1'b0;
    check("contention_cpu_acks", acks, 9);
    drain(40);

    // Reset during a draw: outputs clear at once, no done pulse.
    start_draw(10, 20, 12, 22, 24'hCAFE00, s);
    for (int i = 0; i < 3; i++) push_wr(s + 2 + i, rect_a[i], 24'hCAFE00, 1'b0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_write_en", 32'(wr_en), 0);
    check("abort_write_addr", 32'(wr_addr), 0);
    check("abort_write_data", 32'(wr_data), 0);
    check("abort_cpu_ack", 32'(cpu_ack), 0);
    check("abort_draw_busy", 32'(draw_busy), 0);
    check("abort_draw_done", 32'(draw_done), 0);
    check("abort_writes_seen", exp_q.size(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    start_draw(5, 5, 5, 5, 24'h0000FF, s);
    push_wr(s + 2, 3205, 24'h0000FF, 1'b0);
    done_q.push_back(s + 3);
    drain(40);

    repeat (5) @(negedge clk);
    check("left_writes", exp_q.size(), 0);
    check("left_dones", done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
